// File: rtl/fifo_stream_reader_if.sv
// ============================================================================
// Module      : fifo_stream_reader_if
// Description : FIFO read port plus valid/ready stream port for the reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_stream_reader_if #(
    parameter int WIDTH = 16
);
    logic             fifo_rd_en;
    logic             fifo_empty;
    logic             fifo_underflow;
    logic [WIDTH-1:0] fifo_data_out;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_underflow,
        input  fifo_data_out,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_underflow,
        output fifo_data_out,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// ============================================================================
// Module      : fifo_stream_reader
// Description : Drains a synchronous FIFO into a valid/ready stream through a
//               3-entry skid buffer; keeps delivered count and underflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_stream_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 en,
    fifo_stream_reader_if.master      bus,
    input  wire logic                 clr_stats,
    output logic [CNT_WIDTH-1:0]      rd_count,
    output logic                      err_underflow,
    output logic                      idle
);

    localparam logic [2:0] c_BUF_DEPTH = 3'd3;
    localparam logic [1:0] c_PTR_LAST  = 2'd2;

    logic [FIFO_WIDTH-1:0] r_entry [0:2];
    logic [1:0]            r_head;
    logic [1:0]            r_tail;
    logic [1:0]            r_buf_count;
    logic                  r_inflight;
    logic [CNT_WIDTH-1:0]  r_rd_count;
    logic                  r_err_underflow;

    logic [2:0]            w_occupancy;
    logic                  w_rd_en;
    logic                  w_valid;
    logic                  w_capture;
    logic                  w_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == c_PTR_LAST) ? 2'd0 : ptr + 2'd1;
    endfunction

    // Credit counts the word already in flight so a read is only issued when
    // the buffer is guaranteed a free slot for it, independent of m_ready.
    assign w_occupancy = {1'b0, r_buf_count} + {2'b00, r_inflight};
    assign w_rd_en     = rst_n && en && !bus.fifo_empty && (w_occupancy < c_BUF_DEPTH);
    assign w_valid     = (r_buf_count != 2'd0);
    assign w_capture   = r_inflight;
    assign w_pop       = w_valid && bus.m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_entry[i] <= '0;
            end
            r_tail <= 2'd0;
        end else if (w_capture) begin
            r_entry[r_tail] <= bus.fifo_data_out;
            r_tail          <= ptr_inc(r_tail);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= 2'd0;
        end else if (w_pop) begin
            r_head <= ptr_inc(r_head);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_count <= 2'd0;
        end else begin
            case ({w_capture, w_pop})
                2'b10:   r_buf_count <= r_buf_count + 2'd1;
                2'b01:   r_buf_count <= r_buf_count - 2'd1;
                default: r_buf_count <= r_buf_count;
            endcase
        end
    end

    // Clear takes priority over a coincident handshake or underflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count      <= '0;
            r_err_underflow <= 1'b0;
        end else if (clr_stats) begin
            r_rd_count      <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_count <= r_rd_count + CNT_WIDTH'(1);
            end
            if (bus.fifo_underflow) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_capture && (r_buf_count == 2'd3)));
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = w_valid;
    assign bus.m_data     = r_entry[r_head];
    assign rd_count       = r_rd_count;
    assign err_underflow  = r_err_underflow;
    assign idle           = !w_valid && !r_inflight && bus.fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ============================================================================
// Module      : tb_fifo_stream_reader
// Description : Directed self-checking bench with a registered-read FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_stream_reader;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          clr_stats = 1'b0;
    logic [CW-1:0] rd_count;
    logic          err_underflow;
    logic          idle;

    fifo_stream_reader_if #(.WIDTH(W)) bus ();

    fifo_stream_reader #(
        .FIFO_WIDTH (W),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .bus           (bus),
        .clr_stats     (clr_stats),
        .rd_count      (rd_count),
        .err_underflow (err_underflow),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    // FIFO model: one-cycle registered read data, not affected by reader reset.
    logic [W-1:0] mem [0:63];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    logic [W-1:0] dout = '0;

    assign bus.fifo_empty    = (wr_ptr == rd_ptr);
    assign bus.fifo_data_out = dout;

    always @(posedge clk) begin
        if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
            dout   <= mem[rd_ptr[5:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    logic [W-1:0] recv [0:255];
    int           n_recv = 0;

    always @(posedge clk) begin
        if (bus.m_valid && bus.m_ready) begin
            recv[n_recv[7:0]] <= bus.m_data;
            n_recv            <= n_recv + 1;
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] val);
        mem[wr_ptr[5:0]] = val;
        wr_ptr = wr_ptr + 1;
    endtask

    int nreads;
    int base;

    initial begin
        bus.m_ready        = 1'b0;
        bus.fifo_underflow = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_data", 32'(bus.m_data), 32'd0);
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);

        // Single word
        push(16'hA5A5);
        en          = 1'b1;
        bus.m_ready = 1'b1;
        #1;
        chk("rst_rd_en_held", 32'(bus.fifo_rd_en), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("single_rd_en", 32'(bus.fifo_rd_en), 32'd1);
        tick();
        chk("single_rd_en_drop", 32'(bus.fifo_rd_en), 32'd0);
        chk("single_valid_n1", 32'(bus.m_valid), 32'd0);
        tick();
        chk("single_valid_n2", 32'(bus.m_valid), 32'd1);
        chk("single_data", 32'(bus.m_data), 32'h0000A5A5);
        tick();
        chk("single_valid_n3", 32'(bus.m_valid), 32'd0);
        chk("single_count", 32'(rd_count), 32'd1);
        chk("single_idle", 32'(idle), 32'd1);

        // Streaming at full rate
        en        = 1'b0;
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_count", 32'(rd_count), 32'd0);
        for (int i = 1; i <= 8; i++) push(16'(i));
        en = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            chk("stream_rd_en", 32'(bus.fifo_rd_en), (i < 8) ? 32'd1 : 32'd0);
            chk("stream_valid", 32'(bus.m_valid), (i >= 2 && i < 10) ? 32'd1 : 32'd0);
            if (i >= 2 && i < 10) chk("stream_data", 32'(bus.m_data), 32'(i - 1));
            tick();
        end
        chk("stream_count", 32'(rd_count), 32'd8);
        chk("stream_idle", 32'(idle), 32'd1);

        // Backpressure
        en          = 1'b0;
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(16'(16'h0100 + i));
        nreads = 0;
        en     = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (bus.fifo_rd_en) nreads++;
            if (i >= 2) begin
                chk("bp_hold_valid", 32'(bus.m_valid), 32'd1);
                chk("bp_hold_data", 32'(bus.m_data), 32'h00000101);
            end
            tick();
        end
        chk("bp_reads", 32'(nreads), 32'd3);
        chk("bp_buf_count", 32'(dut.r_buf_count), 32'd3);
        bus.m_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("bp_rel_valid", 32'(bus.m_valid), 32'd1);
            chk("bp_rel_data", 32'(bus.m_data), 32'(16'h0101 + i));
            tick();
        end
        chk("bp_count_wrap", 32'(rd_count), 32'd0);
        chk("bp_idle", 32'(idle), 32'd1);

        // Enable dropped while a read is in flight
        en = 1'b0;
        for (int i = 1; i <= 4; i++) push(16'(16'h0200 + i));
        base = n_recv;
        en   = 1'b1;
        #1;
        chk("en_rd_en", 32'(bus.fifo_rd_en), 32'd1);
        tick();
        en = 1'b0;
        #1;
        chk("en_off_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        tick();
        chk("en_inflight_valid", 32'(bus.m_valid), 32'd1);
        chk("en_inflight_data", 32'(bus.m_data), 32'h00000201);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("en_frozen_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        end
        chk("en_fifo_level", 32'(wr_ptr - rd_ptr), 32'd3);
        chk("en_delivered", 32'(n_recv - base), 32'd1);
        en = 1'b1;
        repeat (8) tick();
        chk("en_resume_total", 32'(n_recv - base), 32'd4);
        chk("en_resume_last", 32'(recv[base + 3]), 32'h00000204);
        chk("en_count", 32'(rd_count), 32'd4);

        // Reset mid-stream
        en          = 1'b0;
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(16'(16'h0300 + i));
        en = 1'b1;
        repeat (3) tick();
        chk("mid_buf_count", 32'(dut.r_buf_count), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.m_valid), 32'd0);
        chk("mid_rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("mid_rst_count", 32'(rd_count), 32'd0);
        tick();
        base        = n_recv;
        rst_n       = 1'b1;
        bus.m_ready = 1'b1;
        repeat (10) tick();
        chk("mid_resume_total", 32'(n_recv - base), 32'd5);
        chk("mid_resume_first", 32'(recv[base]), 32'h00000304);
        chk("mid_resume_last", 32'(recv[base + 4]), 32'h00000308);
        chk("mid_resume_count", 32'(rd_count), 32'd5);

        // Sticky underflow, clear against handshake and underflow
        bus.fifo_underflow = 1'b1;
        tick();
        bus.fifo_underflow = 1'b0;
        chk("uf_set", 32'(err_underflow), 32'd1);
        repeat (2) tick();
        chk("uf_sticky", 32'(err_underflow), 32'd1);
        push(16'h0401);
        base = n_recv;
        tick();
        tick();
        chk("clr_hs_valid", 32'(bus.m_valid), 32'd1);
        clr_stats          = 1'b1;
        bus.fifo_underflow = 1'b1;
        tick();
        clr_stats          = 1'b0;
        bus.fifo_underflow = 1'b0;
        chk("clr_hs_count", 32'(rd_count), 32'd0);
        chk("clr_hs_err", 32'(err_underflow), 32'd0);
        chk("clr_hs_delivered", 32'(n_recv - base), 32'd1);
        chk("clr_hs_data", 32'(recv[base]), 32'h00000401);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side master for the team's synchronous FIFO. It drains the FIFO through rd_en/empty/data_out and presents the words as a valid/ready stream to a downstream consumer.
- Absorbs the FIFO's one-cycle registered read latency with a 3-entry skid buffer. This sustains one word per clock under continuous m_ready and never over-reads.
- Also keeps a delivered-word counter and a sticky underflow error for the verification scoreboard and status registers.

Parameters:
- FIFO_WIDTH, 16, width of FIFO data_out and of m_data.
- CNT_WIDTH, 16, width of the delivered-word counter rd_count.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  read enable; when 0 no new FIFO reads are issued
- fifo_empty  input  1  FIFO empty flag (reflects FIFO count after each edge)
- fifo_underflow  input  1  FIFO underflow flag
- fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid in the cycle after an accepted rd_en
- fifo_rd_en  output  1  FIFO read request (combinational)
- m_valid  output  1  stream word available
- m_data  output  FIFO_WIDTH  stream word (head of skid buffer)
- m_ready  input  1  downstream accepts word
- clr_stats  input  1  synchronous clear of rd_count and err_underflow
- rd_count  output  CNT_WIDTH  number of completed stream handshakes, wraps modulo 2^CNT_WIDTH
- err_underflow  output  1  sticky: FIFO reported underflow
- idle  output  1  nothing buffered, nothing in flight, FIFO empty

Behaviour:
- Clock and reset are decided as follows: one clock, clk. Reset is rst_n, asynchronous, active-low. Async assert, sync deassert handled upstream.
- Reset values:
  - buf_count=0, inflight=0, buffer entries=0.
  - m_valid=0, m_data=0, rd_count=0, err_underflow=0.
  - fifo_rd_en=0 while rst_n=0.
- State:
  - inflight: 1 bit, set to fifo_rd_en at each edge.
  - buf_count: 0..3.
  - 3-entry circular buffer with 2-bit head/tail pointers that wrap 2->0.
- fifo_rd_en = en && !fifo_empty && (buf_count + inflight < 3). It is a function only of registered state, en and fifo_empty. It never depends on m_ready.
- Capture: at an edge where inflight=1, fifo_data_out is written at tail, and tail advances.
- Pop: at an edge where m_valid && m_ready, head advances.
- Count update at each edge: buf_count += capture - pop. Simultaneous capture and pop leaves the count unchanged. Capture into a full buffer is impossible by the credit rule; it is an assertion target.
- Outputs:
  - m_valid = (buf_count != 0).
  - m_data = entry[head].
  - m_data and m_valid are held stable while m_valid && !m_ready.
- Latency: fifo_rd_en asserted in cycle N; word captured at edge ending N+1; m_valid=1 in cycle N+2. The first word after an empty-to-non-empty transition appears 2 cycles after fifo_empty falls.
- Throughput: with m_ready=1 and FIFO non-empty, steady state is buf_count=1, inflight=1, and fifo_rd_en=1 every cycle.
- en=0 mid-stream:
  - No new reads are issued.
  - An in-flight word is still captured.
  - Buffered words are still delivered.
- Ordering: strict FIFO order. No word is dropped or duplicated.
- rd_count increments by 1 per handshake and wraps to 0 after all-ones.
- err_underflow is set at any edge sampling fifo_underflow=1. It stays set until clr_stats or reset.
- clr_stats=1 at an edge:
  - rd_count is set to 0 and err_underflow to 0.
  - Clear wins over a coincident handshake or underflow.
  - Buffer and stream are unaffected.
- idle = !m_valid && !inflight && fifo_empty.
- Reset mid-operation:
  - Buffered and in-flight words are discarded.
  - All outputs return to reset values immediately (asynchronously).

Test Plan:
- Single word: FIFO holds 0xA5A5, en=1, m_ready=1 -> fifo_rd_en pulses 1 cycle; m_valid=1, m_data=0xA5A5 two cycles later for 1 cycle; rd_count=1, idle=1 after.
- Streaming: 8 words 0x0001..0x0008 preloaded, m_ready=1 -> fifo_rd_en high 8 consecutive cycles; m_data 0x0001..0x0008 on 8 consecutive cycles; rd_count=8.
- Backpressure: 8 words, m_ready=0 for 10 cycles then 1 -> exactly 3 reads issued, buf_count=3, m_data=0x0001 held stable; on release, remaining words delivered in order with no gaps after refill, no loss.
- Enable gating: en dropped in the cycle fifo_rd_en is high -> that in-flight word is still delivered; no further reads; FIFO count frozen until en=1.
- Reset mid-stream: rst_n low with buf_count=2 -> m_valid=0, rd_count=0, fifo_rd_en=0 immediately; after release, reading resumes from the current FIFO head.
- Status: force fifo_underflow=1 for 1 cycle -> err_underflow=1 and sticky; clr_stats coincident with a handshake -> rd_count=0, err_underflow=0.
